// File: rtl/locker_pkg.sv
// locker_pkg: shared constants and types for the locker session controller.
//   NUSERS / PWD_W   : number of users and password width
//   PWD_U0..PWD_U3   : stored passwords, STORED_PWD packs them by user index
//   state_e          : session FSM states
//   onehot_to_idx    : one-hot grant -> user index
package locker_pkg;

    localparam int NUSERS = 4;
    localparam int PWD_W  = 12;
    localparam int UIDX_W = 2;

    localparam logic [PWD_W-1:0] PWD_U0 = 12'hF2A;
    localparam logic [PWD_W-1:0] PWD_U1 = 12'h0AA;
    localparam logic [PWD_W-1:0] PWD_U2 = 12'hECE;
    localparam logic [PWD_W-1:0] PWD_U3 = 12'h999;

    localparam logic [NUSERS-1:0][PWD_W-1:0] STORED_PWD = {PWD_U3, PWD_U2, PWD_U1, PWD_U0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        OPEN  = 2'd2,
        DENY  = 2'd3
    } state_e;

    function automatic logic [UIDX_W-1:0] onehot_to_idx(input logic [NUSERS-1:0] oh);
        logic [UIDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUSERS; i++)
            if (oh[i]) idx = UIDX_W'(i);
        return idx;
    endfunction

endpackage

// File: rtl/locker_session_ctrl_if.sv
// locker_session_ctrl_if: user-facing request/response bundle.
//   req, pwd          : per-user request level and entered passwords (master drives)
//   ack, grant_user   : request consumed pulse and serviced user index
//   busy, access      : session in progress / door open
//   denied            : wrong-password pulse
//   alarm, fail_cnt   : per-user lockout flag and 2-bit wrong-entry counters
interface locker_session_ctrl_if;
    import locker_pkg::*;

    logic [NUSERS-1:0]       req;
    logic [NUSERS*PWD_W-1:0] pwd;
    logic [NUSERS-1:0]       ack;
    logic [UIDX_W-1:0]       grant_user;
    logic                    busy;
    logic                    access;
    logic                    denied;
    logic [NUSERS-1:0]       alarm;
    logic [2*NUSERS-1:0]     fail_cnt;

    modport master (
        output req, pwd,
        input  ack, grant_user, busy, access, denied, alarm, fail_cnt
    );

    modport slave (
        input  req, pwd,
        output ack, grant_user, busy, access, denied, alarm, fail_cnt
    );

endinterface

// File: rtl/locker_rr_arbiter.sv
// locker_rr_arbiter: combinational round-robin pick among NUSERS requests.
//   req   : eligible request bits
//   ptr   : highest-priority index this round
//   gnt   : one-hot grant
//   valid : some request was granted
module locker_rr_arbiter
    import locker_pkg::*;
(
    input  logic [NUSERS-1:0] req,
    input  logic [UIDX_W-1:0] ptr,
    output logic [NUSERS-1:0] gnt,
    output logic              valid
);

    logic [UIDX_W-1:0] idx;

    // Walk from ptr upward; NUSERS is a power of two so the index wraps naturally.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUSERS; k++) begin
            idx = ptr + UIDX_W'(k);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/locker_session_ctrl.sv
// locker_session_ctrl: multi-user password locker with round-robin service,
// per-user wrong-entry counting and timed lockout.
//   clk  : clock, all state on posedge
//   rstn : asynchronous reset, active-high
//   bus  : slave side of locker_session_ctrl_if (req/pwd in, status out)
module locker_session_ctrl
    import locker_pkg::*;
#(
    parameter int OPEN_CYCLES = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int MAX_FAIL    = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    locker_session_ctrl_if.slave    bus
);

    localparam int          LTW      = $clog2(LOCK_CYCLES + 1);
    localparam int          OTW      = $clog2(OPEN_CYCLES + 1);
    localparam logic [1:0]  FAIL_SAT = 2'(MAX_FAIL);

    state_e                          state;
    logic [UIDX_W-1:0]               user_q;
    logic [UIDX_W-1:0]               rr_ptr;
    logic [PWD_W-1:0]                pwd_q;
    logic [OTW-1:0]                  open_cnt;
    logic [NUSERS-1:0][LTW-1:0]      lock_tmr;
    logic [NUSERS-1:0][1:0]          fail_q;
    logic [NUSERS-1:0]               alarm_q;
    logic [NUSERS-1:0]               ack_q;
    logic                            busy_q;
    logic                            access_q;
    logic                            denied_q;

    logic [NUSERS-1:0]               eligible;
    logic [NUSERS-1:0]               sel_gnt;
    logic                            sel_valid;
    logic [UIDX_W-1:0]               sel_idx;
    logic [1:0]                      next_fail;
    logic                            pwd_ok;

    // Registered alarm gates eligibility, so a user whose timer expires
    // on this edge only becomes eligible one edge later.
    assign eligible = bus.req & ~alarm_q;

    locker_rr_arbiter u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .gnt   (sel_gnt),
        .valid (sel_valid)
    );

    assign sel_idx   = onehot_to_idx(sel_gnt);
    assign pwd_ok    = (pwd_q == STORED_PWD[user_q]);
    assign next_fail = (fail_q[user_q] < FAIL_SAT) ? fail_q[user_q] + 2'd1 : fail_q[user_q];

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state    <= IDLE;
            user_q   <= '0;
            rr_ptr   <= '0;
            pwd_q    <= '0;
            open_cnt <= '0;
            lock_tmr <= '0;
            fail_q   <= '0;
            alarm_q  <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            access_q <= 1'b0;
            denied_q <= 1'b0;
        end else begin
            // Lock timers run regardless of FSM state. A locked user can never
            // be in session, so the FSM writes below never collide with this.
            for (int i = 0; i < NUSERS; i++) begin
                if (lock_tmr[i] != '0) begin
                    lock_tmr[i] <= lock_tmr[i] - 1'b1;
                    if (lock_tmr[i] == LTW'(1)) begin
                        alarm_q[i] <= 1'b0;
                        fail_q[i]  <= 2'd0;
                    end
                end
            end

            ack_q    <= '0;
            denied_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        pwd_q    <= bus.pwd[sel_idx*PWD_W +: PWD_W];
                        user_q   <= sel_idx;
                        rr_ptr   <= sel_idx + 1'b1;
                        ack_q    <= sel_gnt;
                        busy_q   <= 1'b1;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (pwd_ok) begin
                        state            <= OPEN;
                        access_q         <= 1'b1;
                        fail_q[user_q]   <= 2'd0;
                        open_cnt         <= OTW'(OPEN_CYCLES - 1);
                    end else begin
                        state            <= DENY;
                        denied_q         <= 1'b1;
                        fail_q[user_q]   <= next_fail;
                        if (next_fail == FAIL_SAT) begin
                            alarm_q[user_q]  <= 1'b1;
                            lock_tmr[user_q] <= LTW'(LOCK_CYCLES);
                        end
                    end
                end
                OPEN: begin
                    // Counter was loaded with OPEN_CYCLES-1 on entry, so access
                    // is high for exactly OPEN_CYCLES cycles.
                    if (open_cnt == '0) begin
                        state    <= IDLE;
                        access_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else begin
                        open_cnt <= open_cnt - 1'b1;
                    end
                end
                DENY: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack        = ack_q;
    assign bus.grant_user = user_q;
    assign bus.busy       = busy_q;
    assign bus.access     = access_q;
    assign bus.denied     = denied_q;
    assign bus.alarm      = alarm_q;
    assign bus.fail_cnt   = fail_q;

endmodule
